// File: rtl/waiz_argmax_stage.sv
// Argmax stage for the waiz_benchmark core. It snapshots a logit frame, scans it one element
// per cycle, and holds class index, max logit and top-1/top-2 margin under valid/ready.
module waiz_argmax_stage #(
    parameter int WIDTH       = 16,
    parameter int NFRAC       = 10,
    parameter int OUTPUT_SIZE = 5,
    localparam int IDX_W      = $clog2(OUTPUT_SIZE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data [OUTPUT_SIZE],
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        class_idx,
    output logic signed [WIDTH-1:0] max_value,
    output logic [WIDTH-1:0]        margin,
    output logic [7:0]              drop_count
);

    // state | meaning
    // IDLE  | waiting for a frame strobe
    // SCAN  | comparing snapshot[ptr] against running max/second, one per cycle
    // DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);

    // Empty marker block; it only appears in the hierarchy for an illegal parameter set.
    if (NFRAC < 0 || NFRAC >= WIDTH || OUTPUT_SIZE < 2 || OUTPUT_SIZE > 256) begin : g_param_out_of_range
    end

    state_t state, state_nxt;

    logic signed [WIDTH-1:0] snap [OUTPUT_SIZE];
    logic signed [WIDTH-1:0] max_r, second_r;
    logic [IDX_W-1:0]        idx_r, ptr;

    logic signed [WIDTH-1:0] cur, max_nxt, second_nxt;
    logic [IDX_W-1:0]        idx_nxt;
    logic [WIDTH-1:0]        margin_nxt;
    logic                    last, capture, drop_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cur        = snap[ptr];
        max_nxt    = max_r;
        second_nxt = second_r;
        idx_nxt    = idx_r;
        last       = (ptr == LAST_IDX);
        capture    = 1'b0;
        drop_hit   = 1'b0;

        if (cur > max_r) begin
            second_nxt = max_r;
            max_nxt    = cur;
            idx_nxt    = ptr;
        end else if (cur > second_r) begin
            second_nxt = cur;
        end

        case (state)
            IDLE: begin
                if (in_valid) begin
                    capture   = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                drop_hit = in_valid;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    capture   = in_valid;
                    state_nxt = in_valid ? SCAN : IDLE;
                end else begin
                    drop_hit = in_valid;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Low WIDTH bits of the WIDTH+1-bit difference equal the wrapped WIDTH-bit difference.
    assign margin_nxt = max_nxt - second_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) snap[i] <= '0;
            max_r      <= '0;
            second_r   <= '0;
            idx_r      <= '0;
            ptr        <= '0;
            class_idx  <= '0;
            max_value  <= '0;
            margin     <= '0;
            drop_count <= '0;
        end else begin
            if (capture) begin
                for (int i = 0; i < OUTPUT_SIZE; i++) snap[i] <= in_data[i];
                max_r    <= in_data[0];
                second_r <= MOST_NEG;
                idx_r    <= '0;
                ptr      <= IDX_W'(1);
            end else if (state == SCAN) begin
                max_r    <= max_nxt;
                second_r <= second_nxt;
                idx_r    <= idx_nxt;
                ptr      <= ptr + IDX_W'(1);
                if (last) begin
                    class_idx <= idx_nxt;
                    max_value <= max_nxt;
                    margin    <= margin_nxt;
                end
            end

            if (drop_hit && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_waiz_argmax_stage.sv
// Directed bench for waiz_argmax_stage: table of frames with hand-computed results plus
// sequences for back-pressure, back-to-back frames, mid-scan reset and drop saturation.
module tb_waiz_argmax_stage;

    localparam int W = 16;
    localparam int N = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic signed [W-1:0] in_data [N];
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [2:0]          class_idx;
    logic signed [W-1:0] max_value;
    logic [W-1:0]        margin;
    logic [7:0]          drop_count;

    waiz_argmax_stage #(.WIDTH(W), .NFRAC(10), .OUTPUT_SIZE(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .class_idx  (class_idx),
        .max_value  (max_value),
        .margin     (margin),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][W-1:0] d;
        logic [2:0]          idx;
        logic [W-1:0]        mx;
        logic [W-1:0]        mg;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [7];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d, input int e,
                                input int idx, input int mx, input int mg);
        vec_t r;
        r.d[0] = W'(a); r.d[1] = W'(b); r.d[2] = W'(c); r.d[3] = W'(d); r.d[4] = W'(e);
        r.idx  = 3'(idx);
        r.mx   = W'(mx);
        r.mg   = W'(mg);
        return r;
    endfunction

    task automatic load(input vec_t v);
        for (int i = 0; i < N; i++) in_data[i] = v.d[i];
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) in_data[i] = 16'sh7FFF;
    endtask

    task automatic capture(input vec_t v);
        @(negedge clk);
        load(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("capture_busy", int'(busy), 1);
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            n = k;
            if (out_valid) break;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_idx"},    int'(class_idx), int'(v.idx));
        check({tag, "_max"},    int'(max_value), int'($signed(v.mx)));
        check({tag, "_margin"}, int'(margin),    int'(v.mg));
    endtask

    task automatic accept(input string tag, input vec_t v);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, int'(out_valid), 0);
        check({tag, "_busy_drop"},  int'(busy), 0);
        check({tag, "_idx_kept"},   int'(class_idx), int'(v.idx));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int n;
        out_ready = 1'b1;
        capture(v);
        wait_valid(n);
        check({tag, "_latency"}, n, 4);
        check_result(tag, v);
        accept(tag, v);
    endtask

    initial begin
        int  n;
        bit  ok;

        vecs[0] = mk(-304, 378, 253, -8, 123,        1, 378, 125);
        vecs[1] = mk(100, 900, -50, 900, 20,         1, 900, 0);
        vecs[2] = mk(-32768, -32768, -32768, -32768, -32768, 0, -32768, 0);
        vecs[3] = mk(-32768, -32768, 32767, -32768, -32768,  2, 32767, 65535);
        vecs[4] = mk(5, 4, 3, 2, 1,                  0, 5, 1);
        vecs[5] = mk(-1, -2, -3, -4, 7,              4, 7, 8);
        vecs[6] = mk(0, 0, 0, 0, 0,                  0, 0, 0);

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_data[i] = '0;
        #12;
        check("rst_busy",  int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_idx",   int'(class_idx), 0);
        check("rst_max",   int'(max_value), 0);
        check("rst_margin", int'(margin), 0);
        check("rst_drop",  int'(drop_count), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
        check("drop_after_table", int'(drop_count), 0);

        // Back-pressure with two rejected strobes
        out_ready = 1'b0;
        capture(vecs[0]);
        wait_valid(n);
        check("bp_latency", n, 4);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = (c == 3 || c == 6);
            for (int i = 0; i < N; i++) in_data[i] = 16'sd1000;
            @(posedge clk); #1;
            if (!out_valid || class_idx !== vecs[0].idx || max_value !== $signed(vecs[0].mx) ||
                margin !== vecs[0].mg) ok = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_hold_stable", int'(ok), 1);
        check("bp_drop_count", int'(drop_count), 2);
        check_result("bp", vecs[0]);
        accept("bp", vecs[0]);

        // Back-to-back: accept and new strobe on the same edge
        capture(vecs[4]);
        wait_valid(n);
        check_result("b2b_first", vecs[4]);
        @(negedge clk);
        load(vecs[5]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("b2b_valid_drop", int'(out_valid), 0);
        check("b2b_busy",       int'(busy), 1);
        check("b2b_drop_count", int'(drop_count), 2);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        scramble();
        wait_valid(n);
        check("b2b_latency", n, 4);
        check_result("b2b_second", vecs[5]);
        accept("b2b", vecs[5]);

        // Reset two cycles into SCAN
        capture(vecs[0]);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy",  int'(busy), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_idx",   int'(class_idx), 0);
        check("midrst_max",   int'(max_value), 0);
        check("midrst_margin", int'(margin), 0);
        check("midrst_drop",  int'(drop_count), 0);
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid || busy) ok = 1'b0;
        end
        check("midrst_no_output", int'(ok), 1);
        run_vec("post_rst", vecs[1]);

        // Drop counter saturation
        out_ready = 1'b0;
        capture(vecs[3]);
        wait_valid(n);
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) in_data[i] = 16'sd1000;
        repeat (300) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("sat_drop_count", int'(drop_count), 255);
        check_result("sat", vecs[3]);
        accept("sat", vecs[3]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/waiz_argmax_stage.md
Name: waiz_argmax_stage

Overview:
Downstream classification stage for the waiz_benchmark inference core. It snapshots the OUTPUT_SIZE signed fixed-point logits when the core pulses output_ready, and scans them sequentially, one element per cycle. It produces the winning class index, the winning logit and the top-1/top-2 margin, and holds the result under a valid/ready handshake until the consumer (UART reporter / score logger) accepts it.

Parameters:
WIDTH, 16, logit word width (signed two's complement)
NFRAC, 10, fractional bits of logits; informational only, no arithmetic depends on it
OUTPUT_SIZE, 5, number of logits/classes; legal range 2..256
IDX_W, $clog2(OUTPUT_SIZE), class index width (localparam-derived, not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  one-cycle frame strobe; connect to waiz_benchmark output_ready
in_data  input  WIDTH x OUTPUT_SIZE (unpacked array, signed)  logits; sampled only on an accepted in_valid
busy  output  1  high while a frame is held (SCAN or DONE)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
class_idx  output  IDX_W  index of the maximum logit
max_value  output  WIDTH signed  value of the maximum logit
margin  output  WIDTH unsigned  max_value minus second-largest logit
drop_count  output  8  saturating count of frames rejected while busy

Behaviour:
- Reset (async): state IDLE; busy=0, out_valid=0, class_idx=0, max_value=0, margin=0, drop_count=0; snapshot registers cleared. Reset mid-SCAN or mid-DONE aborts the frame; no output for it.
- States: IDLE, SCAN, DONE.
- IDLE: on in_valid at edge E0, copy all of in_data into the snapshot, set max=data[0], idx=0, second=-2^(WIDTH-1), ptr=1, go to SCAN.
- SCAN: each edge processes snapshot[ptr]:
  - If value > max (strict), then second=max, max=value, idx=ptr.
  - Else if value > second, then second=value.
  - Ties keep the lower index; an equal value still updates second, so the margin is 0.
  - ptr increments. After the edge that processes ptr=OUTPUT_SIZE-1 (edge E(OUTPUT_SIZE-1)), go to DONE with out_valid=1.
- Latency: out_valid rises OUTPUT_SIZE-1 edges after the capture edge (4 cycles for the default).
- Output timing: class_idx, max_value and margin are registered together with the rise of out_valid. They are stable while out_valid=1. They keep their last values after the handshake.
- Margin arithmetic: computed as a WIDTH+1-bit signed difference of max and second; the low WIDTH bits are output as unsigned. The range is 0..2^WIDTH-1, with no overflow.
- DONE: out_valid stays high until out_ready is sampled high, then out_valid=0.
  - If in_valid is also high on that same edge, the new frame is captured and the state goes to SCAN.
  - Otherwise the state goes to IDLE.
- busy is 1 in SCAN and DONE, and 0 in IDLE.
- in_valid while busy (SCAN, or DONE without out_ready) is ignored; the snapshot is unchanged and drop_count increments, saturating at 255.
- in_data changing outside the capture edge has no effect.
- out_ready while not out_valid is ignored.

Test Plan:
- Reset then frame {-304, 378, 253, -8, 123} with out_ready=1 -> out_valid rises 4 edges after capture; class_idx=1, max_value=378, margin=125, busy falls on the accept edge.
- Tie frame {100, 900, -50, 900, 20} -> class_idx=1, max_value=900, margin=0.
- All logits -32768 -> class_idx=0, max_value=-32768, margin=0. Frame {-32768, -32768, 32767, -32768, -32768} -> class_idx=2, margin=65535.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> outputs stable and out_valid held. Pulse in_valid twice during the hold -> drop_count=2, result unchanged. Then out_ready=1 -> out_valid drops next edge.
- Back-to-back: out_ready and a new in_valid on the same edge -> second frame accepted (drop_count unchanged), its result valid 4 edges later.
- Assert reset 2 cycles into SCAN -> out_valid never rises for that frame; all outputs 0. A following frame processes normally.
